// File: rtl/tart_capture_pkg.sv
// rtl/tart_capture_pkg.sv - shared FSM encoding, header magic and byte-count helper for the capture controller
package tart_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  function automatic int calc_bytes(input int num_ant);
    return (num_ant + 7) / 8;
  endfunction

endpackage

// File: rtl/tart_capture_ram.sv
// rtl/tart_capture_ram.sv - simple dual-port sample buffer, one write port, one registered read port
module tart_capture_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // No reset on storage or read data so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tart_capture_ctl.sv
// rtl/tart_capture_ctl.sv - one-shot / ring-trigger antenna capture with oldest-first byte readout
// Optional 4-byte readout header enabled by TART_CAPTURE_HDR_EN.
module tart_capture_ctl
  import tart_capture_pkg::*;
#(
  parameter int NUM_ANT = 24,
  parameter int ADDR_W  = 14
) (
  input  logic               fpga_clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [NUM_ANT-1:0] antenna,
  input  logic               start_aq,
  input  logic               mode,
  input  logic               trigger,
  input  logic [ADDR_W-1:0]  post_count,
  output logic [7:0]         rd_byte,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               bb_filled,
  output logic               busy,
  output logic [2:0]         state_o
);

  localparam int                BYTES     = calc_bytes(NUM_ANT);
  localparam int                PAD_W     = BYTES * 8;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES - 1);

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]  r_wr_ptr, r_cnt, r_rd_addr, r_rd_cnt;
  logic               r_wrapped, r_out_vld;
  logic [1:0]         r_lat, r_byte_idx;
  logic [NUM_ANT-1:0] w_rdata;
  logic [PAD_W-1:0]   w_pad;
  logic [ADDR_W-1:0]  w_raddr;
  logic [7:0]         w_data_byte, w_hdr_byte;
  logic               w_wr_en, w_trig_hit, w_xfer, w_in_hdr;
  logic               w_last_byte, w_last_smp, w_done, w_fetch, w_re;

  assign w_wr_en    = sample_valid &&
                      (r_state == S_FILL || r_state == S_ARMED || r_state == S_POST);
  assign w_trig_hit = (r_state == S_ARMED) && sample_valid && trigger && r_wrapped;

  assign w_xfer      = r_out_vld && rd_ready;
  assign w_last_byte = !w_in_hdr && (r_byte_idx == LAST_BYTE);
  assign w_last_smp  = (r_rd_cnt == ADDR_MAX);
  assign w_done      = w_xfer && w_last_byte && w_last_smp;
  assign w_fetch     = w_xfer && w_last_byte && !w_last_smp;

  // First READOUT cycle reads the oldest sample, which sits at the write pointer.
  assign w_re    = (r_state == S_READOUT) && ((r_lat == 2'd0) || w_fetch);
  assign w_raddr = (r_lat == 2'd0) ? r_wr_ptr : r_rd_addr;

  tart_capture_ram #(
    .DATA_W (NUM_ANT),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (fpga_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (antenna),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_pad       = PAD_W'(w_rdata);
  assign w_data_byte = 8'(w_pad >> (8 * (BYTES - 1 - int'(r_byte_idx))));

  always_ff @(posedge fpga_clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start_aq) w_state_nxt = mode ? S_ARMED : S_FILL;
      S_FILL:    if (sample_valid && r_wr_ptr == ADDR_MAX) w_state_nxt = S_READOUT;
      S_ARMED:   if (w_trig_hit) w_state_nxt = (r_cnt == '0) ? S_READOUT : S_POST;
      S_POST:    if (sample_valid && r_cnt == ADDR_W'(1)) w_state_nxt = S_READOUT;
      S_READOUT: if (w_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    bb_filled = (r_state == S_READOUT);
    state_o   = r_state;
    rd_valid  = r_out_vld;
    rd_byte   = 8'h00;
    if (r_out_vld) rd_byte = w_in_hdr ? w_hdr_byte : w_data_byte;
  end

  // Capture side: r_cnt holds post_count until the trigger, then counts down in POST.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_cnt     <= '0;
      r_wrapped <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start_aq) begin
        r_wr_ptr  <= '0;
        r_wrapped <= 1'b0;
        r_cnt     <= post_count;
      end
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == S_ARMED && r_wr_ptr == ADDR_MAX) r_wrapped <= 1'b1;
      if (r_state == S_POST) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Readout side: RAM output doubles as the holding register while stalled.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n || r_state != S_READOUT) begin
      r_lat      <= 2'd0;
      r_out_vld  <= 1'b0;
      r_byte_idx <= 2'd0;
      r_rd_cnt   <= '0;
      r_rd_addr  <= '0;
    end else begin
      if (r_lat == 2'd0) begin
        r_rd_addr <= r_wr_ptr + 1'b1;
        r_lat     <= 2'd1;
      end else if (r_lat == 2'd1) begin
        r_out_vld <= 1'b1;
        r_lat     <= 2'd2;
      end
      if (w_xfer && !w_in_hdr) begin
        if (w_last_byte) begin
          r_byte_idx <= 2'd0;
          if (w_last_smp) begin
            r_out_vld <= 1'b0;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
            r_rd_cnt  <= r_rd_cnt + 1'b1;
          end
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end
    end
  end

`ifdef TART_CAPTURE_HDR_EN
  logic              r_mode;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [2:0]        r_hdr_idx;
  logic [15:0]       w_trig16;

  assign w_trig16 = 16'(r_trig_addr);
  assign w_in_hdr = !r_hdr_idx[2];

  always_comb begin
    w_hdr_byte = HDR_MAGIC;
    case (r_hdr_idx[1:0])
      2'd0:    w_hdr_byte = HDR_MAGIC;
      2'd1:    w_hdr_byte = {7'b0, r_mode};
      2'd2:    w_hdr_byte = w_trig16[15:8];
      default: w_hdr_byte = w_trig16[7:0];
    endcase
  end

  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_trig_addr <= '0;
      r_hdr_idx   <= 3'd0;
    end else begin
      if (r_state == S_IDLE && start_aq) begin
        r_mode      <= mode;
        r_trig_addr <= '0;
      end else if (w_trig_hit) begin
        r_trig_addr <= r_wr_ptr;
      end
      if (r_state != S_READOUT)    r_hdr_idx <= 3'd0;
      else if (w_xfer && w_in_hdr) r_hdr_idx <= r_hdr_idx + 3'd1;
    end
  end
`else
  assign w_in_hdr   = 1'b0;
  assign w_hdr_byte = 8'h00;
`endif

endmodule
